// File: rtl/blockram_access_ctrl_if.sv
// Request/response bundle between a requester and blockram_access_ctrl.
// Carries the read request/response, the write request and the
// writeback (evict) stream toward the next memory level.
//   master : requester side (drives requests, consumes responses/writebacks)
//   slave  : controller side
interface blockram_access_ctrl_if #(
  parameter int ELEMENT_WIDTH = 64,
  parameter int SET_PTR_WIDTH = 6
);
  logic                     rd_req_valid_in;
  logic                     rd_req_ready_out;
  logic [SET_PTR_WIDTH-1:0] rd_req_addr_in;
  logic                     rd_resp_valid_out;
  logic [ELEMENT_WIDTH-1:0] rd_resp_data_out;
  logic                     wr_req_valid_in;
  logic                     wr_req_ready_out;
  logic [SET_PTR_WIDTH-1:0] wr_req_addr_in;
  logic [ELEMENT_WIDTH-1:0] wr_req_data_in;
  logic                     wb_valid_out;
  logic                     wb_ready_in;
  logic [SET_PTR_WIDTH-1:0] wb_addr_out;
  logic [ELEMENT_WIDTH-1:0] wb_data_out;

  modport master (
    output rd_req_valid_in, rd_req_addr_in,
    output wr_req_valid_in, wr_req_addr_in, wr_req_data_in,
    output wb_ready_in,
    input  rd_req_ready_out, rd_resp_valid_out, rd_resp_data_out,
    input  wr_req_ready_out,
    input  wb_valid_out, wb_addr_out, wb_data_out
  );

  modport slave (
    input  rd_req_valid_in, rd_req_addr_in,
    input  wr_req_valid_in, wr_req_addr_in, wr_req_data_in,
    input  wb_ready_in,
    output rd_req_ready_out, rd_resp_valid_out, rd_resp_data_out,
    output wr_req_ready_out,
    output wb_valid_out, wb_addr_out, wb_data_out
  );
endinterface

// File: rtl/blockram_access_ctrl.sv
// Request-side controller for the dual-port set blockram.
// Accepts reads/writes over valid/ready, returns 1-cycle-latency read
// responses (with same-cycle write bypass), tracks per-set valid bits and
// queues evicted valid elements into a writeback FIFO.
// Ports:
//   clk_in, reset_n_in    : clock, synchronous active-low reset
//   bus (slave)           : read req/resp, write req, writeback stream
//   ram_read_*            : blockram registered read port
//   ram_write_*           : blockram write port
//   ram_evict_element_in  : blockram evict data, valid the cycle after a write
module blockram_access_ctrl #(
  parameter int ELEMENT_WIDTH = 64,
  parameter int NUMBER_SETS   = 64,
  parameter int SET_PTR_WIDTH = 6,
  parameter int WB_FIFO_DEPTH = 4,
  parameter int WB_PTR_WIDTH  = 2
) (
  input  logic                     clk_in,
  input  logic                     reset_n_in,
  blockram_access_ctrl_if.slave    bus,
  output logic                     ram_read_en_out,
  output logic [SET_PTR_WIDTH-1:0] ram_read_set_addr_out,
  input  logic [ELEMENT_WIDTH-1:0] ram_read_element_in,
  output logic                     ram_write_en_out,
  output logic [SET_PTR_WIDTH-1:0] ram_write_set_addr_out,
  output logic [ELEMENT_WIDTH-1:0] ram_write_element_out,
  input  logic [ELEMENT_WIDTH-1:0] ram_evict_element_in
);

  localparam int OCC_W  = WB_PTR_WIDTH + 2;
  localparam int ENTRY_W = SET_PTR_WIDTH + ELEMENT_WIDTH;

  logic                     rd_fire, wr_fire, same_addr;
  logic                     push, pop;
  logic [OCC_W-1:0]         occupancy;

  logic                     rd_resp_valid_q;
  logic                     bypass_q;
  logic [ELEMENT_WIDTH-1:0] bypass_data_q;
  logic                     evict_pending_q;
  logic [SET_PTR_WIDTH-1:0] evict_addr_q;
  logic                     old_valid_q;
  logic [NUMBER_SETS-1:0]   set_valid_q;

  logic [ENTRY_W-1:0]       fifo_q [WB_FIFO_DEPTH];
  logic [WB_PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [WB_PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [WB_PTR_WIDTH:0]    count_q, count_d;

  // Handshake. The pending eviction is counted even if the old element
  // turns out invalid, so a push can never land in a full FIFO.
  assign occupancy            = OCC_W'(count_q) + OCC_W'(evict_pending_q);
  assign bus.rd_req_ready_out = reset_n_in;
  assign bus.wr_req_ready_out = reset_n_in && (occupancy < OCC_W'(WB_FIFO_DEPTH));
  assign rd_fire              = bus.rd_req_valid_in & bus.rd_req_ready_out;
  assign wr_fire              = bus.wr_req_valid_in & bus.wr_req_ready_out;
  assign same_addr            = (bus.rd_req_addr_in == bus.wr_req_addr_in);

  // Blockram drive. Writes only commit under read_en, so a write-only
  // cycle also raises read_en, addressed at the write set.
  assign ram_write_en_out       = wr_fire;
  assign ram_read_en_out        = rd_fire | wr_fire;
  assign ram_read_set_addr_out  = rd_fire ? bus.rd_req_addr_in : bus.wr_req_addr_in;
  assign ram_write_set_addr_out = bus.wr_req_addr_in;
  assign ram_write_element_out  = bus.wr_req_data_in;

  // Read response: RAM returns the pre-write value on a same-cycle hazard,
  // so the registered write data is substituted.
  assign bus.rd_resp_valid_out = rd_resp_valid_q;
  assign bus.rd_resp_data_out  = bypass_q ? bypass_data_q : ram_read_element_in;

  // Writeback FIFO head.
  assign bus.wb_valid_out                  = (count_q != '0);
  assign {bus.wb_addr_out, bus.wb_data_out} = fifo_q[rd_ptr_q];

  always_comb begin
    push     = evict_pending_q & old_valid_q;
    pop      = bus.wb_valid_out & bus.wb_ready_in;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + WB_PTR_WIDTH'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + WB_PTR_WIDTH'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (WB_PTR_WIDTH+1)'(1);
      2'b01:   count_d = count_q - (WB_PTR_WIDTH+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      rd_resp_valid_q <= 1'b0;
      bypass_q        <= 1'b0;
      bypass_data_q   <= '0;
      evict_pending_q <= 1'b0;
      evict_addr_q    <= '0;
      old_valid_q     <= 1'b0;
      set_valid_q     <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
    end else begin
      rd_resp_valid_q <= rd_fire;
      bypass_q        <= rd_fire & wr_fire & same_addr;
      if (wr_fire) bypass_data_q <= bus.wr_req_data_in;
      evict_pending_q <= wr_fire;
      if (wr_fire) begin
        evict_addr_q                    <= bus.wr_req_addr_in;
        old_valid_q                     <= set_valid_q[bus.wr_req_addr_in];
        set_valid_q[bus.wr_req_addr_in] <= 1'b1;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage needs no reset: entries are only visible while count_q != 0.
  always_ff @(posedge clk_in) begin
    if (push) fifo_q[wr_ptr_q] <= {evict_addr_q, ram_evict_element_in};
  end

endmodule

// File: doc/blockram_access_ctrl.md
Name: blockram_access_ctrl

Overview:
Request-side controller that drives the ports of the team's dual-port set blockram (registered read port, write port with registered evict output).
- Accepts read and write requests over valid/ready.
- Returns read responses with same-cycle write bypass.
- Tracks per-set valid bits.
- Queues evicted (previously valid) elements into a writeback FIFO with a valid/ready output toward the next memory level.

Parameters:
ELEMENT_WIDTH, 64, bits per stored element
NUMBER_SETS, 64, number of sets in the attached blockram
SET_PTR_WIDTH, 6, set address width (log2 NUMBER_SETS)
WB_FIFO_DEPTH, 4, writeback FIFO entries (power of two, >=2)
WB_PTR_WIDTH, 2, log2 WB_FIFO_DEPTH

Ports:
clk_in  in  1  clock, all logic on rising edge
reset_n_in  in  1  synchronous active-low reset
rd_req_valid_in  in  1  read request valid
rd_req_ready_out  out  1  read request ready
rd_req_addr_in  in  SET_PTR_WIDTH  read set address
rd_resp_valid_out  out  1  read response valid, single-cycle pulse, no backpressure
rd_resp_data_out  out  ELEMENT_WIDTH  read response data
wr_req_valid_in  in  1  write request valid
wr_req_ready_out  out  1  write request ready
wr_req_addr_in  in  SET_PTR_WIDTH  write set address
wr_req_data_in  in  ELEMENT_WIDTH  write data
wb_valid_out  out  1  writeback entry valid (FIFO head)
wb_ready_in  in  1  downstream accepts writeback
wb_addr_out  out  SET_PTR_WIDTH  set address of evicted element
wb_data_out  out  ELEMENT_WIDTH  evicted element
ram_read_en_out  out  1  to blockram read_en
ram_read_set_addr_out  out  SET_PTR_WIDTH  to blockram read address
ram_read_element_in  in  ELEMENT_WIDTH  from blockram read data (valid cycle after read_en)
ram_write_en_out  out  1  to blockram write_en
ram_write_set_addr_out  out  SET_PTR_WIDTH  to blockram write address
ram_write_element_out  out  ELEMENT_WIDTH  to blockram write data
ram_evict_element_in  in  ELEMENT_WIDTH  from blockram evict data (valid cycle after write)

Behaviour:
- Reset (reset_n_in=0 at edge):
  - rd_resp_valid_out=0, wb_valid_out=0, FIFO pointers/count=0, all set-valid bits=0, evict_pending=0, bypass flag=0.
  - rd_req_ready_out and wr_req_ready_out are 0 while reset_n_in=0.
  - In-flight reads/evictions and FIFO contents are discarded.
- rd_req_ready_out=1 whenever out of reset. rd_fire=valid&ready; wr_fire likewise.
- RAM drive, combinational from request inputs:
  - ram_write_en_out=wr_fire.
  - ram_read_en_out=rd_fire|wr_fire. The blockram commits writes only under read_en, so read_en is forced on for a write-only cycle.
  - ram_read_set_addr_out=rd_req_addr_in if rd_fire, else wr_req_addr_in.
- Read latency 1: rd_resp_valid_out=1 in the cycle after rd_fire. A write-only cycle never produces a response.
- Same-cycle hazard: if rd_fire&wr_fire with equal addresses, register the bypass flag and wr_req_data_in. Next cycle rd_resp_data_out=bypassed data (new value); otherwise rd_resp_data_out=ram_read_element_in.
- Read one cycle after a write to the same address needs no bypass (RAM already updated).
- Eviction:
  - On wr_fire, register evict_pending=1, evict_addr, and old_valid=set_valid[addr]; then set set_valid[addr]=1.
  - Next cycle, if evict_pending&old_valid, push {evict_addr, ram_evict_element_in} into the FIFO.
  - First write to a never-written set pushes nothing.
- Back-to-back writes to the same set: the second eviction carries the first write's data.
- wr_req_ready_out=(fifo_count+evict_pending)<WB_FIFO_DEPTH, counting the pending push conservatively regardless of old_valid.
- FIFO: wb_valid_out=(count!=0), head on wb_addr_out/wb_data_out. A pop occurs on wb_valid_out&wb_ready_in. Push and pop in the same cycle leave the count unchanged; a push into a full FIFO is unreachable by construction.
- Pointers wrap modulo WB_FIFO_DEPTH; count is WB_PTR_WIDTH+1 bits.

Test Plan:
- Reset, then read set 5 -> rd_resp_valid_out pulses exactly 1 cycle later with RAM content; no wb activity.
- Write set 3=0xAA, then write set 3=0xBB -> first write no FIFO push; second pushes {3,0xAA}; wb_valid_out=1 two cycles after the second accept.
- Same-cycle read+write set 7 (old 0x11, new 0x22) -> response=0x22; read set 7 next cycle -> 0x22; wb entry {7,0x11} if set 7 was previously valid.
- Fill sets 0..5 then rewrite 0..5 with wb_ready_in=0 -> wr_req_ready_out drops once count+pending=4; exactly 4 entries queued in order 0,1,2,3; release wb_ready_in -> drained in order, writes resume.
- Write-only cycle to set 9 -> ram_read_en_out=1, ram_read_set_addr_out=9, no rd_resp_valid_out.
- Assert reset_n_in=0 with 3 FIFO entries and an eviction pending -> next cycle wb_valid_out=0, count=0; subsequent write to a previously written set pushes nothing (valid bits cleared).
